mag_comp_1bit: RTL and testbench
================================

MAG_COMP_1BIT -- requirements
Module: mag_comp_1bit

Interface
REQ-001 SHALL have parameter: CNT_W, 8, width of each saturating result counter (legal range 1..16).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: A  input  1  first operand.
REQ-005 SHALL have port: B  input  1  second operand.
REQ-006 SHALL have port: in_valid  input  1  A/B/cascade inputs are sampled this cycle.
REQ-007 SHALL have port: gt_in, lt_in, eq_in  input  1 each  cascade inputs from a less-significant stage; standalone use ties eq_in=1, gt_in=lt_in=0.
REQ-008 SHALL have port: clr_cnt  input  1  synchronous clear of all counters.
REQ-009 SHALL have port: L  output  1  registered A<B result.
REQ-010 SHALL have port: G  output  1  registered A>B result.
REQ-011 SHALL have port: E  output  1  registered A==B result.
REQ-012 SHALL have port: out_valid  output  1  L/G/E updated from a sampled input in the previous cycle.
REQ-013 SHALL have ports: cnt_lt, cnt_gt, cnt_eq  output  CNT_W each  number of valid results of each kind.

Function
REQ-014 SHALL compute, when in_valid=1 at a rising edge: A=1,B=0 -> G=1,L=0,E=0; A=0,B=1 -> L=1,G=0,E=0.
REQ-015 SHALL, when A==B, pass the cascade through with priority gt_in > lt_in > eq_in; if none is asserted, E=1.
REQ-016 SHALL keep {L,G,E} exactly one-hot after any valid sample; never two outputs high.
REQ-017 SHALL have latency one clock: result visible on L/G/E and out_valid=1 the cycle after in_valid=1.
REQ-018 SHALL, when in_valid=0, hold L/G/E unchanged and drive out_valid=0 the next cycle.
REQ-019 SHALL increment exactly one of cnt_lt/cnt_gt/cnt_eq on each valid sample, matching the result being registered.
REQ-020 SHALL saturate each counter at 2^CNT_W-1; no wrap-around.
REQ-021 SHALL, when clr_cnt=1, zero all counters at the next edge; clr_cnt wins over a simultaneous increment (that sample is not counted) but does not affect L/G/E/out_valid.
REQ-022 SHALL accept back-to-back valid samples every cycle with no stall.

Reset
REQ-023 SHALL, while rst=1, immediately force L=0, G=0, E=0, out_valid=0 and all counters to 0, independent of clk.
REQ-024 SHALL discard a sample presented in the same cycle rst deasserts only if rst is still high at that edge; first result appears one cycle after the first in_valid edge with rst=0.
REQ-025 SHALL abandon any pending result and clear counters on reset asserted mid-operation.

Structure
REQ-026 SHALL place the CNT_W default and a result encoding (LT, GT, EQ) in shared package mag_comp_pkg.
REQ-027 SHALL implement the combinational compare-plus-cascade logic in one sub-module mag_comp_cell (inputs A, B, gt_in, lt_in, eq_in; outputs lt, gt, eq); the top adds registers, valid pipeline and counters.

Verification
REQ-028 SHALL cover: standalone cascade (eq_in=1), apply {A,B}=00,01,10,11 on consecutive cycles with in_valid=1 -> one cycle later E=1; L=1; G=1; E=1; cnt_eq=2, cnt_lt=1, cnt_gt=1.
REQ-029 SHALL cover: A=B=1 with gt_in=1,lt_in=1,eq_in=1 -> G=1; with all cascade inputs 0 -> E=1.
REQ-030 SHALL cover: valid A=0,B=1, then in_valid=0 with A=1,B=0 -> L stays 1, out_valid=0, counters unchanged.
REQ-031 SHALL cover: CNT_W=2, five consecutive A=1,B=0 valid samples -> cnt_gt=3 (saturated).
REQ-032 SHALL cover: clr_cnt=1 together with valid A=0,B=1 -> all counters 0 next cycle, L=1, out_valid=1.
REQ-033 SHALL cover: rst asserted between clock edges after results exist -> L=G=E=0, out_valid=0, counters 0 before the next edge.

Source files
------------

// File: rtl/mag_comp_pkg.sv
// Shared definitions for the 1-bit magnitude comparator slice.
package mag_comp_pkg;

    // Default width of each saturating result counter.
    localparam int unsigned CNT_W_DEFAULT = 8;

    // Result encoding for one comparison.
    typedef enum logic [1:0] {
        RES_LT = 2'd0,
        RES_GT = 2'd1,
        RES_EQ = 2'd2
    } result_e;

    // Map the one-hot cell outputs onto the result encoding.
    // The cell guarantees one-hot, so EQ is the fall-through.
    function automatic result_e encode_result(input logic lt, input logic gt);
        if (gt) begin
            return RES_GT;
        end else if (lt) begin
            return RES_LT;
        end
        return RES_EQ;
    endfunction

endpackage

// File: rtl/mag_comp_cell.sv
// Combinational 1-bit compare with cascade from a less-significant stage.
module mag_comp_cell (
    input  logic A,
    input  logic B,
    input  logic gt_in,
    input  logic lt_in,
    input  logic eq_in,
    output logic lt,
    output logic gt,
    output logic eq
);

    logic same;

    // Local bit decides; on a tie the cascade passes with gt_in > lt_in > eq_in.
    // eq_in is not needed to produce eq: a tie with no gt_in/lt_in is equal.
    always_comb begin
        same = ~(A ^ B);
        gt   = (A & ~B) | (same & gt_in);
        lt   = (~A & B) | (same & ~gt_in & lt_in);
        eq   = same & ~gt_in & ~lt_in;
        // eq_in only documents standalone tie-off; the result is unaffected.
        if (eq_in) begin
            eq = same & ~gt_in & ~lt_in;
        end
    end

endmodule

// File: rtl/mag_comp_1bit.sv
// Registered 1-bit magnitude comparator with valid pipeline and
// per-result saturating counters.
module mag_comp_1bit
    import mag_comp_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             A,
    input  logic             B,
    input  logic             in_valid,
    input  logic             gt_in,
    input  logic             lt_in,
    input  logic             eq_in,
    input  logic             clr_cnt,
    output logic             L,
    output logic             G,
    output logic             E,
    output logic             out_valid,
    output logic [CNT_W-1:0] cnt_lt,
    output logic [CNT_W-1:0] cnt_gt,
    output logic [CNT_W-1:0] cnt_eq
);

    logic             cell_lt, cell_gt, cell_eq;
    result_e          res;
    logic             l_q, g_q, e_q, v_q;
    logic             l_d, g_d, e_d, v_d;
    logic [CNT_W-1:0] cnt_lt_q, cnt_gt_q, cnt_eq_q;
    logic [CNT_W-1:0] cnt_lt_d, cnt_gt_d, cnt_eq_d;

    mag_comp_cell u_cell (
        .A     (A),
        .B     (B),
        .gt_in (gt_in),
        .lt_in (lt_in),
        .eq_in (eq_in),
        .lt    (cell_lt),
        .gt    (cell_gt),
        .eq    (cell_eq)
    );

    // Result registers load on a valid sample and hold otherwise.
    always_comb begin
        res = encode_result(cell_lt, cell_gt);
        l_d = l_q;
        g_d = g_q;
        e_d = e_q;
        v_d = in_valid;
        if (in_valid) begin
            l_d = cell_lt;
            g_d = cell_gt;
            e_d = cell_eq;
        end
    end

    // Counters: clear wins over a same-cycle increment; saturate at all-ones.
    always_comb begin
        cnt_lt_d = cnt_lt_q;
        cnt_gt_d = cnt_gt_q;
        cnt_eq_d = cnt_eq_q;
        if (clr_cnt) begin
            cnt_lt_d = '0;
            cnt_gt_d = '0;
            cnt_eq_d = '0;
        end else if (in_valid) begin
            unique case (res)
                RES_LT:  if (cnt_lt_q != '1) cnt_lt_d = cnt_lt_q + 1'b1;
                RES_GT:  if (cnt_gt_q != '1) cnt_gt_d = cnt_gt_q + 1'b1;
                default: if (cnt_eq_q != '1) cnt_eq_d = cnt_eq_q + 1'b1;
            endcase
        end
    end

    // State register with asynchronous reset of results and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            l_q      <= 1'b0;
            g_q      <= 1'b0;
            e_q      <= 1'b0;
            v_q      <= 1'b0;
            cnt_lt_q <= '0;
            cnt_gt_q <= '0;
            cnt_eq_q <= '0;
        end else begin
            l_q      <= l_d;
            g_q      <= g_d;
            e_q      <= e_d;
            v_q      <= v_d;
            cnt_lt_q <= cnt_lt_d;
            cnt_gt_q <= cnt_gt_d;
            cnt_eq_q <= cnt_eq_d;
        end
    end

    assign L         = l_q;
    assign G         = g_q;
    assign E         = e_q;
    assign out_valid = v_q;
    assign cnt_lt    = cnt_lt_q;
    assign cnt_gt    = cnt_gt_q;
    assign cnt_eq    = cnt_eq_q;

endmodule

// File: tb/tb_mag_comp_1bit.sv
// Directed self-checking bench for mag_comp_1bit (default and CNT_W=2).
module tb_mag_comp_1bit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       A = 1'b0, B = 1'b0, in_valid = 1'b0;
    logic       gt_in = 1'b0, lt_in = 1'b0, eq_in = 1'b1, clr_cnt = 1'b0;
    logic       L, G, E, out_valid;
    logic [7:0] cnt_lt, cnt_gt, cnt_eq;
    logic       L2, G2, E2, out_valid2;
    logic [1:0] cnt_lt2, cnt_gt2, cnt_eq2;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    mag_comp_1bit #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .in_valid(in_valid),
        .gt_in(gt_in), .lt_in(lt_in), .eq_in(eq_in), .clr_cnt(clr_cnt),
        .L(L), .G(G), .E(E), .out_valid(out_valid),
        .cnt_lt(cnt_lt), .cnt_gt(cnt_gt), .cnt_eq(cnt_eq)
    );

    mag_comp_1bit #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .A(A), .B(B), .in_valid(in_valid),
        .gt_in(gt_in), .lt_in(lt_in), .eq_in(eq_in), .clr_cnt(clr_cnt),
        .L(L2), .G(G2), .E(E2), .out_valid(out_valid2),
        .cnt_lt(cnt_lt2), .cnt_gt(cnt_gt2), .cnt_eq(cnt_eq2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check {L,G,E}, out_valid and {cnt_lt,cnt_gt,cnt_eq} of the 8-bit instance.
    task automatic chk_all(input string tag, input logic [2:0] lge, input logic ov,
                           input logic [7:0] clt, input logic [7:0] cgt, input logic [7:0] ceq);
        chk({tag, ".LGE"}, {29'd0, L, G, E}, {29'd0, lge});
        chk({tag, ".ov"}, {31'd0, out_valid}, {31'd0, ov});
        chk({tag, ".cnt"}, {8'd0, cnt_lt, cnt_gt, cnt_eq}, {8'd0, clt, cgt, ceq});
    endtask

    task automatic step(input logic a, input logic b, input logic v, input logic clr);
        A = a; B = b; in_valid = v; clr_cnt = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset asserted from time zero, before any edge.
        #2;
        chk_all("rst0", 3'b000, 1'b0, 8'd0, 8'd0, 8'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Standalone cascade: 00,01,10,11 back to back.
        step(1'b0, 1'b0, 1'b1, 1'b0); chk_all("s00", 3'b001, 1'b1, 8'd0, 8'd0, 8'd1);
        step(1'b0, 1'b1, 1'b1, 1'b0); chk_all("s01", 3'b100, 1'b1, 8'd1, 8'd0, 8'd1);
        step(1'b1, 1'b0, 1'b1, 1'b0); chk_all("s10", 3'b010, 1'b1, 8'd1, 8'd1, 8'd1);
        step(1'b1, 1'b1, 1'b1, 1'b0); chk_all("s11", 3'b001, 1'b1, 8'd1, 8'd1, 8'd2);

        // Cascade priority on a tie.
        gt_in = 1'b1; lt_in = 1'b1; eq_in = 1'b1;
        step(1'b1, 1'b1, 1'b1, 1'b0); chk_all("casc_all", 3'b010, 1'b1, 8'd1, 8'd2, 8'd2);
        gt_in = 1'b0; lt_in = 1'b1; eq_in = 1'b1;
        step(1'b0, 1'b0, 1'b1, 1'b0); chk_all("casc_lt", 3'b100, 1'b1, 8'd2, 8'd2, 8'd2);
        gt_in = 1'b0; lt_in = 1'b0; eq_in = 1'b0;
        step(1'b1, 1'b1, 1'b1, 1'b0); chk_all("casc_none", 3'b001, 1'b1, 8'd2, 8'd2, 8'd3);
        // Local inequality overrides cascade.
        gt_in = 1'b1; lt_in = 1'b0; eq_in = 1'b0;
        step(1'b0, 1'b1, 1'b1, 1'b0); chk_all("local_lt", 3'b100, 1'b1, 8'd3, 8'd2, 8'd3);
        gt_in = 1'b0; eq_in = 1'b1;

        // Invalid sample holds results and counters.
        step(1'b1, 1'b0, 1'b0, 1'b0); chk_all("hold", 3'b100, 1'b0, 8'd3, 8'd2, 8'd3);

        // Clear with no sample, then saturation in the 2-bit instance.
        step(1'b0, 1'b0, 1'b0, 1'b1); chk_all("clr_idle", 3'b100, 1'b0, 8'd0, 8'd0, 8'd0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
        chk_all("gt5", 3'b010, 1'b1, 8'd0, 8'd5, 8'd0);
        chk("sat_gt2", {30'd0, cnt_gt2}, 32'd3);
        chk("sat_lg2", {28'd0, cnt_lt2, cnt_eq2}, 32'd0);

        // Clear wins over a simultaneous valid sample; result still registers.
        step(1'b0, 1'b1, 1'b1, 1'b1); chk_all("clr_valid", 3'b100, 1'b1, 8'd0, 8'd0, 8'd0);

        // Asynchronous reset between edges after results exist.
        step(1'b1, 1'b0, 1'b1, 1'b0); chk_all("pre_rst", 3'b010, 1'b1, 8'd0, 8'd1, 8'd0);
        #2 rst = 1'b1;
        #1;
        chk_all("async_rst", 3'b000, 1'b0, 8'd0, 8'd0, 8'd0);

        // Sample at an edge with rst still high is discarded.
        step(1'b0, 1'b1, 1'b1, 1'b0); chk_all("rst_edge", 3'b000, 1'b0, 8'd0, 8'd0, 8'd0);
        rst = 1'b0;
        step(1'b0, 1'b1, 1'b1, 1'b0); chk_all("post_rst", 3'b100, 1'b1, 8'd1, 8'd0, 8'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0); chk_all("post_idle", 3'b100, 1'b0, 8'd1, 8'd0, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
